// File: rtl/noc_packet_fifo.sv
// Circular-buffer FIFO of NoC packets, first-word-fall-through.
// Optional same-cycle empty bypass when PACKET_FIFO_BYPASS_EN is defined.
package noc_pkg;
  typedef struct packed {
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [3:0]  x_src;
    logic [3:0]  y_src;
    logic        ant;
    logic        backward;
    logic [1:0]  memory;
    logic [31:0] data;
  } packet_t;
endpackage

module noc_packet_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    ce,
  input  packet_t i_data,
  input  logic    i_data_val,
  input  logic    i_en,
  output packet_t o_data,
  output logic    o_data_val,
  output logic    o_en
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  packet_t          storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic has_data;
  logic bypass;
  logic wr;
  logic rd;

  assign has_data = reset_n & (count != '0);
  assign o_en     = reset_n & (count != FULL);

`ifdef PACKET_FIFO_BYPASS_EN
  // Empty FIFO hands the offered packet straight through when taken now.
  assign bypass = ce & reset_n & ~has_data & i_data_val & i_en;
`else
  assign bypass = 1'b0;
`endif

  assign wr = ce & reset_n & i_data_val & o_en & ~bypass;
  assign rd = ce & reset_n & i_en & has_data;

  always_comb begin
    o_data     = '0;
    o_data_val = 1'b0;
    unique case (1'b1)
      bypass: begin
        o_data     = i_data;
        o_data_val = 1'b1;
      end
      has_data: begin
        o_data     = storage[rd_ptr];
        o_data_val = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) storage[wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (ce) begin
      if (wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packet_fifo.sv
// Directed bench for noc_packet_fifo at DEPTH=4.
// Checks reset, fill, drain, wrap streaming, full+read and clock enable.
module tb_noc_packet_fifo;
  import noc_pkg::*;

  logic    clk = 1'b0;
  logic    reset_n;
  logic    ce;
  packet_t i_data;
  logic    i_data_val;
  logic    i_en;
  packet_t o_data;
  logic    o_data_val;
  logic    o_en;

  int checks = 0;
  int errors = 0;

  noc_packet_fifo #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .i_en       (i_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .o_en       (o_en)
  );

  always #5 clk = ~clk;

  function automatic packet_t mk(input int x);
    packet_t p;
    logic [7:0] b;
    b = 8'(x);
    p          = '0;
    p.x_dest   = b[3:0];
    p.y_dest   = ~b[3:0];
    p.x_src    = 4'h3;
    p.y_src    = b[7:4];
    p.ant      = b[0];
    p.backward = b[1];
    p.memory   = b[2:1];
    p.data     = 32'hA5000000 | 32'(x);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    ce         = 1'b1;
    i_data     = mk(9);
    i_data_val = 1'b1;
    i_en       = 1'b0;
    #1;
    chk("rst_oen_t0", 64'(o_en), 64'd0);
    chk("rst_val_t0", 64'(o_data_val), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_oen", 64'(o_en), 64'd0);
      chk("rst_val", 64'(o_data_val), 64'd0);
      chk("rst_data", 64'(o_data), 64'd0);
    end
    reset_n    = 1'b1;
    i_data_val = 1'b0;
    #1;
    chk("post_rst_oen", 64'(o_en), 64'd1);
    chk("post_rst_val", 64'(o_data_val), 64'd0);

    // fill
    for (int i = 0; i < 4; i++) begin
      i_data     = mk(i);
      i_data_val = 1'b1;
      step();
      chk("fill_head", 64'(o_data), 64'(mk(0)));
      chk("fill_val", 64'(o_data_val), 64'd1);
      chk("fill_oen", 64'(o_en), (i < 3) ? 64'd1 : 64'd0);
    end
    i_data = mk(5);
    step();
    chk("full_oen", 64'(o_en), 64'd0);
    chk("full_head", 64'(o_data), 64'(mk(0)));

    // drain
    i_data_val = 1'b0;
    i_en       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_head", 64'(o_data), 64'(mk(k)));
      chk("drain_val", 64'(o_data_val), 64'd1);
      step();
    end
    chk("drain_empty_val", 64'(o_data_val), 64'd0);
    chk("drain_empty_data", 64'(o_data), 64'd0);
    chk("drain_empty_oen", 64'(o_en), 64'd1);

    // streaming with wrap
    for (int c = 0; c < 10; c++) begin
      i_data     = mk(16 + c);
      i_data_val = 1'b1;
      step();
      chk("stream_head", 64'(o_data), 64'(mk(16 + c)));
      chk("stream_val", 64'(o_data_val), 64'd1);
      chk("stream_oen", 64'(o_en), 64'd1);
    end
    i_data_val = 1'b0;
    step();
    chk("stream_end_val", 64'(o_data_val), 64'd0);

    // full plus simultaneous read
    i_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_data     = mk(40 + i);
      i_data_val = 1'b1;
      step();
    end
    chk("fr_full_oen", 64'(o_en), 64'd0);
    i_data = mk(44);
    i_en   = 1'b1;
    step();
    chk("fr_rej_head", 64'(o_data), 64'(mk(41)));
    chk("fr_rej_oen", 64'(o_en), 64'd1);
    step();
    chk("fr_acc_head", 64'(o_data), 64'(mk(42)));
    chk("fr_acc_oen", 64'(o_en), 64'd1);

    // clock enable low freezes everything
    ce         = 1'b0;
    i_data     = mk(50);
    i_data_val = 1'b1;
    i_en       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ce_head", 64'(o_data), 64'(mk(42)));
      chk("ce_val", 64'(o_data_val), 64'd1);
      chk("ce_oen", 64'(o_en), 64'd1);
    end
    ce         = 1'b1;
    i_data_val = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ce_drain", 64'(o_data), 64'(mk(42 + k)));
      step();
    end
    chk("ce_drain_empty", 64'(o_data_val), 64'd0);

    // reset mid-operation discards queued packets
    i_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_data     = mk(60 + i);
      i_data_val = 1'b1;
      step();
    end
    chk("mid_head", 64'(o_data), 64'(mk(60)));
    reset_n = 1'b0;
    step();
    reset_n    = 1'b1;
    i_data_val = 1'b0;
    #1;
    chk("mid_rst_val", 64'(o_data_val), 64'd0);
    chk("mid_rst_oen", 64'(o_en), 64'd1);
    i_data     = mk(70);
    i_data_val = 1'b1;
    step();
    chk("mid_rst_new", 64'(o_data), 64'(mk(70)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_packet_fifo.md
Name: noc_packet_fifo

Overview:
- Synchronous circular-buffer FIFO of packet_t words (the codebase NoC packet struct).
- One instance per node sits between the node's traffic source and the network's local input port.
- Absorbs packets the network cannot accept immediately.
- Presents the head packet to the router with a valid flag, and signals upstream whether space remains.

Parameters:
- DEPTH, default 8, number of packet_t entries; any integer >= 2 (power of two not required).
- CNT_W, default $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  reset; one clock, reset is synchronous and active-low.
- ce  input  1  clock enable; 0 freezes all state.
- i_data  input  packet_t  packet from upstream source.
- i_data_val  input  1  upstream offers i_data this cycle.
- i_en  input  1  downstream (router) accepts head packet this cycle.
- o_data  output  packet_t  head packet to router.
- o_data_val  output  1  o_data holds a valid packet (FIFO non-empty).
- o_en  output  1  FIFO can accept a write this cycle (not full); upstream enable / inverse saturation flag.

Behaviour:
- State:
  - DEPTH-entry storage array.
  - Read pointer rd_ptr and write pointer wr_ptr, each 0..DEPTH-1.
  - Occupancy count, 0..DEPTH.
- Pointer wrap: a pointer equal to DEPTH-1 increments to 0. Explicit compare, no power-of-two masking.
- Write event: wr = ce & reset_n & i_data_val & o_en. On posedge: storage[wr_ptr] <= i_data; wr_ptr advances.
- Read event: rd = ce & reset_n & i_en & o_data_val. On posedge: rd_ptr advances.
- Count update: +1 on wr only; -1 on rd only; unchanged on both or neither.
- o_data_val = (count != 0) & reset_n. Combinational from state; does not depend on i_en.
- o_en = (count != DEPTH) & reset_n. Combinational from state; does not depend on i_en.
- o_data = storage[rd_ptr] when o_data_val, else all-zero packet. First-word-fall-through.
- Latency: a packet written at edge N is visible on o_data with o_data_val=1 immediately after edge N. No same-cycle bypass unless the optional feature is enabled.
- Full boundary (count=DEPTH):
  - o_en=0; writes blocked even if a read occurs in the same cycle.
  - Upstream retries next cycle; an offered packet is simply not accepted.
- Empty boundary (count=0):
  - o_data_val=0, o_data=0; i_en ignored.
  - Write proceeds normally.
- Simultaneous wr and rd with 0<count<DEPTH: both pointers advance, count unchanged, head advances in order.
- ce=0: no pointer, count or storage change. Outputs keep reflecting current state.
- Reset:
  - While reset_n=0: o_en=0, o_data_val=0, o_data=0.
  - On a posedge with reset_n=0: rd_ptr=0, wr_ptr=0, count=0. Storage contents are not cleared.
  - Reset mid-operation discards all queued packets.
  - After reset_n rises: o_en=1, o_data_val=0.
- Ordering: strict FIFO; packet fields are passed through unmodified, including ant, backward and memory fields.
- No overflow or underflow is possible because wr/rd are gated by o_en/o_data_val.

Optional Feature:
- Macro: PACKET_FIFO_BYPASS_EN.
- Defined:
  - When count=0, ce=1, i_data_val=1 and i_en=1, i_data is presented combinationally on o_data with o_data_val=1.
  - The packet is consumed in the same cycle; no storage write and no count change.
  - In all other cases, behaviour is as without the macro.
- Undefined: no combinational path from i_data/i_data_val to o_data/o_data_val. Empty FIFO always shows o_data_val=0.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with i_data_val=1 -> o_en=0, o_data_val=0 throughout. After release, o_en=1 and count=0.
- Fill, DEPTH=4, i_en=0: write packets with x_dest=0,1,2,3 -> after the 4th edge, o_en=0 and o_data.x_dest=0. A 5th offered packet (x_dest=5) is not stored.
- Drain: from full, i_en=1, i_data_val=0 -> o_data.x_dest sequence 0,1,2,3 on consecutive cycles, then o_data_val=0.
- Streaming with wrap, DEPTH=4, i_data_val=1, i_en=1, for 10 cycles with sequential x_dest:
  - Output order is preserved and count stays at 1.
  - Pointers wrap 3->0 without loss.
- Full plus simultaneous read: count=4, i_en=1, i_data_val=1 -> write rejected and count becomes 3. Next cycle the write is accepted and count stays 3.
- ce=0 with i_data_val=1 and i_en=1 for 3 cycles -> count, pointers and o_data unchanged.
